// File: rtl/mem_data_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: port 0 has fixed
// priority, port 1 is guaranteed a slot after STARVE_LIMIT consecutive denials.
`default_nettype none

module mem_data_arbiter #(
  parameter int unsigned WORD_LEN     = 16,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_LEN-1:0] p0_addr,
  input  logic [WORD_LEN-1:0] p0_wdata,
  output logic                p0_gnt,
  output logic [WORD_LEN-1:0] p0_rdata,
  output logic                p0_rvalid,

  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_LEN-1:0] p1_addr,
  input  logic [WORD_LEN-1:0] p1_wdata,
  output logic                p1_gnt,
  output logic [WORD_LEN-1:0] p1_rdata,
  output logic                p1_rvalid,

  output logic [ADDR_LEN-1:0] mem_address,
  output logic [WORD_LEN-1:0] mem_dataIn,
  output logic                mem_writeEn,
  input  logic [WORD_LEN-1:0] mem_dataOut,

  output logic                busy,
  output logic                owner
);

  // Handshake: a requester holds req and its command stable until it sees its
  // gnt. The gnt cycle is the single memory access cycle; the edge that ends it
  // samples req again, so a port may issue one command per cycle back-to-back.
  // Reads return rdata with a one-cycle rvalid pulse on the following cycle.

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_data_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic                act_valid;
  logic                act_we;
  logic [ADDR_LEN-1:0] act_addr;
  logic [WORD_LEN-1:0] act_wdata;
  logic                owner_q;
  logic [CW-1:0]       starve_cnt;

  logic                req_any;
  logic                starve_hit;
  logic                win1;
  logic [CW-1:0]       starve_nxt;
  logic                rd_done;

  always_comb begin
    req_any    = p0_req | p1_req;
    starve_hit = (starve_cnt == CW'(STARVE_LIMIT));
    // Port 1 wins alone, or when it has been denied STARVE_LIMIT times in a row.
    win1       = p1_req & (~p0_req | starve_hit);
    starve_nxt = '0;
    if (p0_req && p1_req && !starve_hit) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_valid  <= 1'b0;
      act_we     <= 1'b0;
      act_addr   <= '0;
      act_wdata  <= '0;
      owner_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (req_any) begin
        act_valid <= 1'b1;
        owner_q   <= win1;
        act_we    <= win1 ? p1_we    : p0_we;
        act_addr  <= win1 ? p1_addr  : p0_addr;
        act_wdata <= win1 ? p1_wdata : p0_wdata;
      end else begin
        act_valid <= 1'b0;
      end
    end
  end

  // The memory reads combinationally, so the data is captured at the edge
  // that closes the read access cycle.
  assign rd_done = act_valid & ~act_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= rd_done & ~owner_q;
      p1_rvalid <= rd_done &  owner_q;
      if (rd_done && !owner_q) begin
        p0_rdata <= mem_dataOut;
      end
      if (rd_done && owner_q) begin
        p1_rdata <= mem_dataOut;
      end
    end
  end

  // Address and write data hold their last values while idle.
  assign mem_address = act_addr;
  assign mem_dataIn  = act_wdata;
  assign mem_writeEn = act_valid & act_we;
  assign p0_gnt      = act_valid & ~owner_q;
  assign p1_gnt      = act_valid &  owner_q;
  assign busy        = act_valid;
  assign owner       = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a falling-edge-write memory model
// and per-port expected-read-data queues.
`timescale 1ns/1ps

module tb_mem_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_address, mem_dataIn, mem_dataOut;
  logic        mem_writeEn, busy, owner;

  logic [15:0] mem [256];
  logic [15:0] sh  [256];
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        exp_own;

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_writeEn === 1'b1) mem[mem_address[8:1]] <= mem_dataIn;
  end
  assign mem_dataOut = mem[mem_address[8:1]];

  mem_data_arbiter #(.WORD_LEN(16), .ADDR_LEN(16), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_writeEn(mem_writeEn),
    .mem_dataOut(mem_dataOut), .busy(busy), .owner(owner)
  );

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p0"}, {p0_gnt, p0_rvalid, p0_rdata}, 80'd0);
    chk({tag, "_p1"}, {p1_gnt, p1_rvalid, p1_rdata}, 80'd0);
    chk({tag, "_mem"}, {mem_address, mem_dataIn, mem_writeEn, busy, owner}, 80'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    chk("gnt_mutex", {79'd0, p0_gnt & p1_gnt}, 80'd0);
    if (p0_rvalid === 1'b1) begin
      if (exp0_q.size() == 0) chk("p0_unexpected_rvalid", 80'(exp0_q.size()), 80'd1);
      else chk("p0_rdata", p0_rdata, exp0_q.pop_front());
    end
    if (p1_rvalid === 1'b1) begin
      if (exp1_q.size() == 0) chk("p1_unexpected_rvalid", 80'(exp1_q.size()), 80'd1);
      else chk("p1_rdata", p1_rdata, exp1_q.pop_front());
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h5A00 + 16'(i * 3);
      sh[i]  = 16'h5A00 + 16'(i * 3);
    end
    rst = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0020; p0_wdata = 16'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0040; p1_wdata = 16'h0;

    // reset with both requesting
    repeat (2) begin
      tick();
      chk_all_zero("rst_hold");
    end
    rst = 1'b0;
    #2 chk_all_zero("rst_fall");

    // contention: p0 first, p1 next cycle
    exp0_q.push_back(sh[8'h10]);
    exp1_q.push_back(sh[8'h20]);
    tick();
    chk("cont_g0", {p0_gnt, p1_gnt, owner}, 3'b100);
    p0_req = 1'b0;
    tick();
    chk("cont_g1", {p0_gnt, p1_gnt, owner}, 3'b011);
    chk("cont_rv0", {p0_rvalid, p1_rvalid}, 2'b10);
    p1_req = 1'b0;
    tick();
    chk("cont_rv1", {p0_rvalid, p1_rvalid, busy}, 3'b010);

    // port-0 write then read of the same word
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    sh[8'h08] = 16'hBEEF;
    tick();
    chk("wr_gnt", {p0_gnt, mem_writeEn, busy, owner}, 4'b1110);
    chk("wr_bus", {mem_address, mem_dataIn}, {16'h0010, 16'hBEEF});
    p0_we = 1'b0; p0_wdata = 16'h0;
    exp0_q.push_back(sh[8'h08]);
    tick();
    chk("rd_gnt", {p0_gnt, mem_writeEn, p0_rvalid}, 3'b100);
    chk("rd_addr", mem_address, 16'h0010);
    p0_req = 1'b0;
    tick();
    chk("rd_resp", {p0_gnt, busy, p0_rvalid, p0_rdata}, {3'b001, 16'hBEEF});
    chk("idle_hold", {mem_address, mem_writeEn}, {16'h0010, 1'b0});
    tick();
    chk("rd_hold", {p0_rvalid, p0_rdata}, {1'b0, 16'hBEEF});

    // odd address passes through unmodified
    p0_req = 1'b1; p0_addr = 16'h0011;
    exp0_q.push_back(sh[8'h08]);
    tick();
    chk("odd_addr", {p0_gnt, mem_address}, {1'b1, 16'h0011});
    p0_req = 1'b0;
    tick();
    tick();

    // starvation guard: both held -> 0,0,0,1,0,0,0,1
    p0_addr = 16'h0030; p1_addr = 16'h0040;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_own = ((i % 4) == 3);
      chk("starve_gnt", {p0_gnt, p1_gnt}, exp_own ? 2'b01 : 2'b10);
      if (exp_own) exp1_q.push_back(sh[8'h20]);
      else         exp0_q.push_back(sh[8'h18]);
      if (i == 2) chk("starve_peak", dut.starve_cnt, 3);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();

    // reset while a read is in flight: no rvalid afterwards
    p0_req = 1'b1; p0_addr = 16'h0020;
    tick();
    chk("rif_gnt", p0_gnt, 1'b1);
    rst = 1'b1; p0_req = 1'b0;
    tick();
    chk("rif_drop", {p0_gnt, p0_rvalid, busy, mem_writeEn}, 4'b0000);
    rst = 1'b0;
    tick();

    // reset during a port-1 write: write still commits, nothing after
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0050; p1_wdata = 16'h1234;
    tick();
    chk("rmw_gnt", {p1_gnt, mem_writeEn}, 2'b11);
    rst = 1'b1; p0_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rmw_off", {p0_gnt, p1_gnt, mem_writeEn, busy, p0_rvalid, p1_rvalid}, 6'd0);
      chk("rmw_mem", mem[8'h28], 16'h1234);
    end
    rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0; p1_wdata = 16'h0;
    sh[8'h28] = 16'h1234;
    tick();
    chk("rmw_idle", {busy, mem_writeEn}, 2'b00);

    // port-1 readback of the interrupted write
    p1_req = 1'b1; p1_addr = 16'h0050;
    exp1_q.push_back(sh[8'h28]);
    tick();
    chk("rb_gnt", {p0_gnt, p1_gnt}, 2'b01);
    p1_req = 1'b0;
    tick();
    chk("rb_resp", {p1_rvalid, p1_rdata}, {1'b1, 16'h1234});
    tick();

    // back-to-back port-1 reads
    p1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p1_addr = 16'(i * 2);
      exp1_q.push_back(sh[i]);
      tick();
      chk("b2b_gnt", {p1_gnt, p1_rvalid}, {1'b1, (i != 0)});
    end
    p1_req = 1'b0;
    tick();
    chk("b2b_last", {p1_gnt, p1_rvalid}, 2'b01);
    tick();
    chk("b2b_end", {p1_gnt, p1_rvalid}, 2'b00);
    tick();

    chk("q0_drained", 80'(exp0_q.size()), 80'd0);
    chk("q1_drained", 80'(exp1_q.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
